// File: rtl/alu_exec_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
// - ALU control code localparams (the same encoding the ALU decoder emits).
// - FSM state enum used by alu_exec.
// - is_shift(): true for the three shift codes.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_NAND = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operation/result handshake bundle of the execute-stage ALU.
// Upstream side: i_valid/o_ready with i_ctrl, i_a, i_b.
// Downstream side: o_valid/i_ready with o_result, o_zero; o_busy flags a running shift.
// slave  : seen from the ALU.
// master : seen from the surrounding pipeline (or a testbench).
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [3:0]      i_ctrl;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_zero;
    logic            o_busy;

    modport slave (
        input  i_valid, i_ctrl, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_zero, o_busy
    );

    modport master (
        output i_valid, i_ctrl, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_zero, o_busy
    );
endinterface

// File: rtl/alu_logic.sv
// alu_logic: purely combinational single-cycle ALU results.
// Ports: i_ctrl (ALU code), i_a/i_b (operands) -> o_result.
// Undefined codes 12-15 give 0. Shift codes give 0 unless ALU_FAST_SHIFT_EN
// is defined, in which case they are computed by a barrel shifter here.
module alu_logic
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_ctrl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);
`ifdef ALU_FAST_SHIFT_EN
    localparam int SHW = $clog2(XLEN);
`endif

    // Result mux over the control code.
    always_comb begin
        o_result = {XLEN{1'b0}};
        case (i_ctrl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NAND: o_result = ~(i_a & i_b);
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  o_result = i_a << i_b[SHW-1:0];
            ALU_SRL:  o_result = i_a >> i_b[SHW-1:0];
            ALU_SRA:  o_result = $signed(i_a) >>> i_b[SHW-1:0];
`endif
            default:  o_result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with valid/ready handshakes.
// Ports: i_clk, i_rst_n (async, active-low), bus (alu_exec_if.slave):
//   i_valid/o_ready/i_ctrl/i_a/i_b upstream, o_valid/i_ready/o_result/o_zero
//   downstream, o_busy while an iterative shift runs.
// Build option ALU_FAST_SHIFT_EN: shifts go through the barrel shifter in
// alu_logic with 1-cycle latency; the SHIFT state and counter disappear and
// o_busy is tied low. Without it, shifts move one bit per cycle.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    alu_exec_if.slave bus
);
    state_t          state_r, state_s;
    logic [XLEN-1:0] result_r, result_s;
    logic [XLEN-1:0] logic_res_s;
    logic            ready_s;
    logic            load_s;
`ifndef ALU_FAST_SHIFT_EN
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    logic [SHW-1:0]  cnt_r, cnt_s;
    logic [3:0]      kind_r, kind_s;
    logic [SHW-1:0]  shamt_s;

    assign shamt_s = bus.i_b[SHW-1:0];
`endif

    alu_logic #(.XLEN(XLEN)) u_logic (
        .i_ctrl   (bus.i_ctrl),
        .i_a      (bus.i_a),
        .i_b      (bus.i_b),
        .o_result (logic_res_s)
    );

    // Next-state, work-register step and handshake decode.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        ready_s  = 1'b0;
        load_s   = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
        cnt_s    = cnt_r;
        kind_s   = kind_r;
`endif
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                load_s  = bus.i_valid;
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                case (kind_r)
                    ALU_SLL: result_s = {result_r[XLEN-2:0], 1'b0};
                    ALU_SRL: result_s = {1'b0, result_r[XLEN-1:1]};
                    ALU_SRA: result_s = {result_r[XLEN-1], result_r[XLEN-1:1]};
                    default: result_s = result_r;
                endcase
                cnt_s = cnt_r - CNT_ONE;
                // A count of 1 means this step is the final one.
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
`endif
            DONE: begin
                // Draining and accepting may share one edge.
                ready_s = bus.i_ready;
                if (bus.i_ready) begin
                    if (bus.i_valid) begin
                        load_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase

        // Accept path: identical whether entered from IDLE or DONE.
        if (load_s) begin
`ifndef ALU_FAST_SHIFT_EN
            if (is_shift(bus.i_ctrl)) begin
                result_s = bus.i_a;
                if (shamt_s != {SHW{1'b0}}) begin
                    cnt_s   = shamt_s;
                    kind_s  = bus.i_ctrl;
                    state_s = SHIFT;
                end else begin
                    state_s = DONE;
                end
            end else begin
                result_s = logic_res_s;
                state_s  = DONE;
            end
`else
            result_s = logic_res_s;
            state_s  = DONE;
`endif
        end else begin
            result_s = result_s;
        end
    end

    // State, result/work register and shift bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            result_r <= {XLEN{1'b0}};
`ifndef ALU_FAST_SHIFT_EN
            cnt_r    <= {SHW{1'b0}};
            kind_r   <= 4'd0;
`endif
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
`ifndef ALU_FAST_SHIFT_EN
            cnt_r    <= cnt_s;
            kind_r   <= kind_s;
`endif
        end
    end

    assign bus.o_ready  = ready_s;
    assign bus.o_valid  = (state_r == DONE);
    assign bus.o_result = result_r;
    // o_zero is only meaningful alongside o_valid, so it is masked otherwise.
    assign bus.o_zero   = (state_r == DONE) && (result_r == {XLEN{1'b0}});
`ifndef ALU_FAST_SHIFT_EN
    assign bus.o_busy   = (state_r == SHIFT);
`else
    assign bus.o_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed + randomized self-checking bench for alu_exec.
// Expected results come from ref_model(), written from the arithmetic rules;
// expected latency of a shift is its shift amount (0 with ALU_FAST_SHIFT_EN).
module tb_alu_exec;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a ^ b;
            4'd3:  return ~(a & b);
            4'd4:  return ~(a | b);
            4'd5:  begin s = {1'b0, a} + {1'b0, b}; return s[31:0]; end
            4'd6:  begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; return s[31:0]; end
            4'd7:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            4'd8:  return {31'd0, (a < b)};
            4'd9:  return a << sh;
            4'd10: return a >> sh;
            4'd11: begin ext = {{32{a[31]}}, a}; ext = ext >> sh; return ext[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE: accept, wait (bounded) for the result, check, drain.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] exp;
        int          kexp;
        int          cyc;
        int          busy;
        exp  = ref_model(c, a, b);
        kexp = (!FAST && (c == 4'd9 || c == 4'd10 || c == 4'd11)) ? int'(b[4:0]) : 0;
        bus.i_ctrl  = c;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b0;
        #1;
        check({tag, ".accept_ready"}, {31'd0, bus.o_ready}, 32'd1);
        tick();
        bus.i_valid = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        bus.i_ctrl  = 4'($urandom);
        cyc  = 0;
        busy = 0;
        while (bus.o_valid !== 1'b1 && cyc < 100) begin
            if (bus.o_busy === 1'b1) busy++;
            tick();
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(kexp));
        check({tag, ".busy_cycles"}, 32'(busy), 32'(kexp));
        check({tag, ".result"}, bus.o_result, exp);
        check({tag, ".zero"}, {31'd0, bus.o_zero}, {31'd0, (exp == 32'd0)});
        check({tag, ".busy_at_done"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, ".hold_ready"}, {31'd0, bus.o_ready}, 32'd0);
        bus.i_ready = 1'b1;
        #1;
        check({tag, ".drain_ready"}, {31'd0, bus.o_ready}, 32'd1);
        tick();
        bus.i_ready = 1'b0;
        check({tag, ".after_drain_valid"}, {31'd0, bus.o_valid}, 32'd0);
        check({tag, ".after_drain_zero"}, {31'd0, bus.o_zero}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, {31'd0, bus.o_ready}, 32'd1);
        check({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd0);
        check({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, ".result"}, bus.o_result, 32'd0);
        check({tag, ".zero"}, {31'd0, bus.o_zero}, 32'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] exp_sub;
        logic [31:0] exp_xor;
        bit          seen;

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_ctrl  = 4'd0;
        bus.i_a     = 32'd0;
        bus.i_b     = 32'd0;
        #1 rst_n = 1'b0;
        #11;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed operations from the test plan.
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(4'd11, 32'h8000_0000, 32'd4, "sra4");
        run_op(4'd10, 32'h8000_0000, 32'd4, "srl4");
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, "slt");
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_op(4'd4, 32'd0, 32'd0, "nor");
        run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, "undef13");
        run_op(4'd9, 32'h1234_5678, 32'd0, "sll0");
        run_op(4'd9, 32'h0000_0003, 32'd31, "sll31");
        run_op(4'd3, 32'hF0F0_FFFF, 32'h0FF0_F0F0, "nand");

        // SUB held for 5 cycles with a queued XOR, then drain+accept together.
        exp_sub = ref_model(4'd6, 32'd7, 32'd9);
        bus.i_ctrl = 4'd6; bus.i_a = 32'd7; bus.i_b = 32'd9;
        bus.i_valid = 1'b1; bus.i_ready = 1'b0;
        tick();
        ea = 32'hF0F0_1234; eb = 32'h0FF0_4321;
        exp_xor = ref_model(4'd2, ea, eb);
        bus.i_ctrl = 4'd2; bus.i_a = ea; bus.i_b = eb;
        for (int i = 0; i < 5; i++) begin
            check("hold.valid", {31'd0, bus.o_valid}, 32'd1);
            check("hold.result", bus.o_result, exp_sub);
            check("hold.ready", {31'd0, bus.o_ready}, 32'd0);
            tick();
        end
        bus.i_ready = 1'b1;
        #1;
        check("overlap.ready", {31'd0, bus.o_ready}, 32'd1);
        tick();
        bus.i_valid = 1'b0;
        check("overlap.valid", {31'd0, bus.o_valid}, 32'd1);
        check("overlap.result", bus.o_result, exp_xor);
        tick();
        check("overlap.drained", {31'd0, bus.o_valid}, 32'd0);
        bus.i_ready = 1'b0;

        // Reset pulsed on the 3rd cycle of SLL by 20.
        bus.i_ctrl = 4'd9; bus.i_a = 32'd1; bus.i_b = 32'd20;
        bus.i_valid = 1'b1; bus.i_ready = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midshift_reset");
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.o_valid === 1'b1) seen = 1'b1;
            tick();
        end
        check("midshift_reset.no_valid", {31'd0, seen}, 32'd0);
        bus.i_ready = 1'b0;
        run_op(4'd5, 32'd2, 32'd3, "add_after_reset");

        // Eight back-to-back ADDs, one result per cycle, in order.
        bus.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ea = $urandom; eb = $urandom;
            bus.i_ctrl = 4'd5; bus.i_a = ea; bus.i_b = eb; bus.i_valid = 1'b1;
            q.push_back(ref_model(4'd5, ea, eb));
            #1;
            check("stream.ready", {31'd0, bus.o_ready}, 32'd1);
            tick();
            check("stream.valid", {31'd0, bus.o_valid}, 32'd1);
            check("stream.result", bus.o_result, q.pop_front());
        end
        bus.i_valid = 1'b0;
        tick();
        check("stream.drained", {31'd0, bus.o_valid}, 32'd0);
        bus.i_ready = 1'b0;

        // Randomized operations over all 16 codes.
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
